// File: rtl/axil_pkg.sv
// Shared AXI-Lite widths, response codes and FSM state types for the register file slave.
package axil_pkg;

   localparam int AXIL_ADDR_WIDTH = 32;
   localparam int AXIL_DATA_WIDTH = 32;

   localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

   typedef enum logic {
      W_IDLE,
      W_RESP
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_t;

endpackage

// File: rtl/axil_if.sv
// AXI-Lite bus bundle (protection signals intentionally not carried).
interface axil_if;
   import axil_pkg::*;

   logic [AXIL_ADDR_WIDTH-1:0]   awaddr;
   logic                         awvalid;
   logic                         awready;
   logic [AXIL_DATA_WIDTH-1:0]   wdata;
   logic [AXIL_DATA_WIDTH/8-1:0] wstrb;
   logic                         wvalid;
   logic                         wready;
   logic [1:0]                   bresp;
   logic                         bvalid;
   logic                         bready;
   logic [AXIL_ADDR_WIDTH-1:0]   araddr;
   logic                         arvalid;
   logic                         arready;
   logic [AXIL_DATA_WIDTH-1:0]   rdata;
   logic [1:0]                   rresp;
   logic                         rvalid;
   logic                         rready;

   modport s_axil (
      input  awaddr, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input  araddr, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );

   modport m_axil (
      output awaddr, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bresp, bvalid, output bready,
      output araddr, arvalid, input arready,
      input  rdata, rresp, rvalid, output rready
   );

endinterface

// File: rtl/axil_regfile_slave.sv
// AXI-Lite register file slave: independent write/read FSMs over a byte-strobed register array.
// Define AXIL_REGFILE_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_regfile_slave
   import axil_pkg::*;
#(
   parameter int unsigned NUM_REGS    = 16,
   parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
   input  logic                                     aclk,
   input  logic                                     aresetn,
   axil_if.s_axil                                   s_axil,
   output logic [NUM_REGS-1:0][AXIL_DATA_WIDTH-1:0] regs_out
);

   localparam int unsigned IDX_W  = $clog2(NUM_REGS);
   localparam int unsigned STRB_W = AXIL_DATA_WIDTH / 8;
   localparam logic [AXIL_ADDR_WIDTH-1:0] ADDR_LIMIT = AXIL_ADDR_WIDTH'(NUM_REGS * 4);

   function automatic logic addr_oor(input logic [AXIL_ADDR_WIDTH-1:0] addr);
      return (addr >= ADDR_LIMIT);
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [AXIL_ADDR_WIDTH-1:0] addr);
      return addr[2 +: IDX_W];
   endfunction

   function automatic logic [AXIL_DATA_WIDTH-1:0] byte_merge(
      input logic [AXIL_DATA_WIDTH-1:0] old_word,
      input logic [AXIL_DATA_WIDTH-1:0] new_word,
      input logic [STRB_W-1:0]          strb
   );
      logic [AXIL_DATA_WIDTH-1:0] merged;
      merged = old_word;
      for (int k = 0; k < STRB_W; k++) begin
         if (strb[k]) merged[8*k +: 8] = new_word[8*k +: 8];
      end
      return merged;
   endfunction

   // ---------------- write channel ----------------
   wr_state_t                  wr_state, wr_state_d;
   logic                       awready_q, awready_d;
   logic                       wready_q, wready_d;
   logic                       bvalid_q, bvalid_d;
   logic [1:0]                 bresp_q, bresp_d;
   logic                       aw_lat, aw_lat_d;
   logic                       w_lat, w_lat_d;
   logic [AXIL_ADDR_WIDTH-1:0] aw_addr_lat;
   logic [AXIL_DATA_WIDTH-1:0] w_data_lat;
   logic [STRB_W-1:0]          w_strb_lat;

   logic                       aw_hs, w_hs, aw_have, w_have;
   logic [AXIL_ADDR_WIDTH-1:0] wr_addr;
   logic [AXIL_DATA_WIDTH-1:0] wr_data;
   logic [STRB_W-1:0]          wr_strb;
   logic                       wr_oor, wr_en;

   // A channel arriving on this edge is used directly; otherwise the latched copy.
   assign aw_hs   = s_axil.awvalid & awready_q;
   assign w_hs    = s_axil.wvalid & wready_q;
   assign aw_have = aw_lat | aw_hs;
   assign w_have  = w_lat | w_hs;
   assign wr_addr = aw_hs ? s_axil.awaddr : aw_addr_lat;
   assign wr_data = w_hs ? s_axil.wdata : w_data_lat;
   assign wr_strb = w_hs ? s_axil.wstrb : w_strb_lat;
   assign wr_oor  = addr_oor(wr_addr);

   always_comb begin
      wr_state_d = wr_state;
      awready_d  = awready_q;
      wready_d   = wready_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      aw_lat_d   = aw_lat;
      w_lat_d    = w_lat;
      wr_en      = 1'b0;
      case (wr_state)
         W_IDLE: begin
            aw_lat_d  = aw_have;
            w_lat_d   = w_have;
            awready_d = ~aw_have;
            wready_d  = ~w_have;
            if (aw_have && w_have) begin
               wr_state_d = W_RESP;
               aw_lat_d   = 1'b0;
               w_lat_d    = 1'b0;
               awready_d  = 1'b0;
               wready_d   = 1'b0;
               bvalid_d   = 1'b1;
               wr_en      = ~wr_oor;
`ifdef AXIL_REGFILE_SLVERR_EN
               bresp_d    = wr_oor ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
`else
               bresp_d    = AXIL_RESP_OKAY;
`endif
            end
         end
         W_RESP: begin
            if (s_axil.bready) begin
               wr_state_d = W_IDLE;
               bvalid_d   = 1'b0;
               awready_d  = 1'b1;
               wready_d   = 1'b1;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_state  <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= AXIL_RESP_OKAY;
         aw_lat    <= 1'b0;
         w_lat     <= 1'b0;
      end else begin
         wr_state  <= wr_state_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         aw_lat    <= aw_lat_d;
         w_lat     <= w_lat_d;
      end
   end

   // Payload holding registers; only meaningful while the matching *_lat flag is set.
   always_ff @(posedge aclk) begin
      if (aw_hs) aw_addr_lat <= s_axil.awaddr;
      if (w_hs) begin
         w_data_lat <= s_axil.wdata;
         w_strb_lat <= s_axil.wstrb;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < NUM_REGS; i++) regs_out[i] <= RESET_VALUE;
      end else if (wr_en) begin
         regs_out[addr_idx(wr_addr)] <= byte_merge(regs_out[addr_idx(wr_addr)], wr_data, wr_strb);
      end
   end

   assign s_axil.awready = awready_q;
   assign s_axil.wready  = wready_q;
   assign s_axil.bvalid  = bvalid_q;
   assign s_axil.bresp   = bresp_q;

   // ---------------- read channel ----------------
   rd_state_t                  rd_state, rd_state_d;
   logic                       arready_q, arready_d;
   logic                       rvalid_q, rvalid_d;
   logic [1:0]                 rresp_q, rresp_d;
   logic [AXIL_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                       ar_hs, rd_oor;

   assign ar_hs  = s_axil.arvalid & arready_q;
   assign rd_oor = addr_oor(s_axil.araddr);

   // Sampling regs_out before the edge gives old data on a same-edge write collision.
   always_comb begin
      rd_state_d = rd_state;
      arready_d  = arready_q;
      rvalid_d   = rvalid_q;
      rresp_d    = rresp_q;
      rdata_d    = rdata_q;
      case (rd_state)
         R_IDLE: begin
            arready_d = 1'b1;
            if (ar_hs) begin
               rd_state_d = R_DATA;
               arready_d  = 1'b0;
               rvalid_d   = 1'b1;
               rdata_d    = rd_oor ? '0 : regs_out[addr_idx(s_axil.araddr)];
`ifdef AXIL_REGFILE_SLVERR_EN
               rresp_d    = rd_oor ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
`else
               rresp_d    = AXIL_RESP_OKAY;
`endif
            end
         end
         R_DATA: begin
            if (s_axil.rready) begin
               rd_state_d = R_IDLE;
               rvalid_d   = 1'b0;
               arready_d  = 1'b1;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_state  <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= AXIL_RESP_OKAY;
         rdata_q   <= '0;
      end else begin
         rd_state  <= rd_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
      end
   end

   assign s_axil.arready = arready_q;
   assign s_axil.rvalid  = rvalid_q;
   assign s_axil.rresp   = rresp_q;
   assign s_axil.rdata   = rdata_q;

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Scoreboard bench for axil_regfile_slave: B/R expectations queued at issue, checked at handshake.
module tb_axil_regfile_slave;
   import axil_pkg::*;

   localparam int          NREGS   = 16;
   localparam logic [31:0] RST_VAL = 32'h0000_0000;
`ifdef AXIL_REGFILE_SLVERR_EN
   localparam logic [1:0]  OOR_RESP = AXIL_RESP_SLVERR;
`else
   localparam logic [1:0]  OOR_RESP = AXIL_RESP_OKAY;
`endif

   logic                   aclk = 1'b0;
   logic                   aresetn = 1'b0;
   logic [NREGS-1:0][31:0] regs_out;

   axil_if bus ();

   axil_regfile_slave #(
      .NUM_REGS    (NREGS),
      .RESET_VALUE (RST_VAL)
   ) dut (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .s_axil   (bus),
      .regs_out (regs_out)
   );

   always #5 aclk = ~aclk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [1:0]  b_q[$];
   logic [33:0] r_q[$];
   logic [31:0] model[NREGS];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   function automatic logic in_range(input logic [31:0] a);
      return a < NREGS * 4;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [3:0] idx;
      idx = a[5:2];
      if (in_range(a)) begin
         for (int k = 0; k < 4; k++) if (s[k]) model[idx][8*k +: 8] = d[8*k +: 8];
      end
      b_q.push_back(in_range(a) ? AXIL_RESP_OKAY : OOR_RESP);
   endtask

   task automatic expect_read(input logic [31:0] a);
      logic [3:0] idx;
      idx = a[5:2];
      if (in_range(a)) r_q.push_back({AXIL_RESP_OKAY, model[idx]});
      else             r_q.push_back({OOR_RESP, 32'h0});
   endtask

   task automatic drive_aw(input logic [31:0] a);
      logic hs;
      int   n;
      bus.awaddr = a; bus.awvalid = 1'b1; n = 0;
      do begin hs = bus.awready; tick(); n++; end while (!hs && n < 50);
      if (!hs) check("aw_timeout", 0, 1);
      bus.awvalid = 1'b0;
   endtask

   task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
      logic hs;
      int   n;
      bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1; n = 0;
      do begin hs = bus.wready; tick(); n++; end while (!hs && n < 50);
      if (!hs) check("w_timeout", 0, 1);
      bus.wvalid = 1'b0;
   endtask

   task automatic drive_ar(input logic [31:0] a);
      logic hs;
      int   n;
      bus.araddr = a; bus.arvalid = 1'b1; n = 0;
      do begin hs = bus.arready; tick(); n++; end while (!hs && n < 50);
      if (!hs) check("ar_timeout", 0, 1);
      bus.arvalid = 1'b0;
   endtask

   // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead);
      model_write(a, d, s);
      if (lead == 0) begin
         fork
            drive_aw(a);
            drive_w(d, s);
         join
      end else if (lead > 0) begin
         fork
            drive_w(d, s);
            begin repeat (lead) tick(); drive_aw(a); end
         join
      end else begin
         fork
            drive_aw(a);
            begin repeat (-lead) tick(); drive_w(d, s); end
         join
      end
      check("bvalid_latency", bus.bvalid, 1);
   endtask

   task automatic wait_b();
      int         n;
      logic [1:0] exp;
      bus.bready = 1'b1; n = 0;
      while (!bus.bvalid && n < 50) begin tick(); n++; end
      if (!bus.bvalid) check("b_timeout", 0, 1);
      else if (b_q.size() == 0) check("b_unexpected", 1, 0);
      else begin
         exp = b_q.pop_front();
         check("bresp", bus.bresp, exp);
         tick();
      end
      bus.bready = 1'b0;
      check("bvalid_clear", bus.bvalid, 0);
   endtask

   task automatic wait_r();
      int          n;
      logic [33:0] exp;
      bus.rready = 1'b1; n = 0;
      while (!bus.rvalid && n < 50) begin tick(); n++; end
      if (!bus.rvalid) check("r_timeout", 0, 1);
      else if (r_q.size() == 0) check("r_unexpected", 1, 0);
      else begin
         exp = r_q.pop_front();
         check("rdata", bus.rdata, exp[31:0]);
         check("rresp", bus.rresp, exp[33:32]);
         tick();
      end
      bus.rready = 1'b0;
      check("rvalid_clear", bus.rvalid, 0);
   endtask

   task automatic do_read(input logic [31:0] a, input int hold);
      logic [33:0] exp;
      expect_read(a);
      exp = r_q[r_q.size()-1];
      drive_ar(a);
      check("rvalid_latency", bus.rvalid, 1);
      for (int i = 0; i < hold; i++) begin
         check("rdata_hold", bus.rdata, exp[31:0]);
         tick();
      end
      wait_r();
   endtask

   task automatic check_all_regs(input string tag);
      for (int i = 0; i < NREGS; i++) check(tag, regs_out[i], model[i]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a, d;
      logic [3:0]  s;

      bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
      bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      for (int i = 0; i < NREGS; i++) model[i] = RST_VAL;

      repeat (3) tick();
      check("rst_awready", bus.awready, 0);
      check("rst_wready", bus.wready, 0);
      check("rst_arready", bus.arready, 0);
      check("rst_bvalid", bus.bvalid, 0);
      check("rst_rvalid", bus.rvalid, 0);
      check("rst_rdata", bus.rdata, 0);
      check("rst_bresp", bus.bresp, 0);
      check("rst_rresp", bus.rresp, 0);
      check_all_regs("rst_regs");

      aresetn = 1'b1;
      tick();
      check("post_rst_awready", bus.awready, 1);
      check("post_rst_wready", bus.wready, 1);
      check("post_rst_arready", bus.arready, 1);

      // AW and W together
      do_write(32'h04, 32'hDEADBEEF, 4'hF, 0);
      check("reg1_write", regs_out[1], 32'hDEADBEEF);
      wait_b();

      // W two cycles ahead of AW, partial strobes
      do_write(32'h08, 32'hFFFFFFFF, 4'hF, 0);
      wait_b();
      do_write(32'h08, 32'h12345678, 4'b0101, 2);
      check("wready_held", bus.wready, 0);
      check("reg2_strobe", regs_out[2], 32'hFF34FF78);
      wait_b();
      check("wready_back", bus.wready, 1);
      check("awready_back", bus.awready, 1);

      // AW ahead of W
      do_write(32'h14, 32'h0BADF00D, 4'b1100, -1);
      wait_b();
      check_all_regs("after_aw_first");

      // read-back with rready held low
      do_read(32'h04, 5);
      do_read(32'h0A, 0);

      // out of range
      do_write(32'h40, 32'hCAFEF00D, 4'hF, 0);
      wait_b();
      check_all_regs("oor_write");
      do_read(32'h40, 0);

      // same-edge read/write collision
      expect_read(32'h0C);
      model_write(32'h0C, 32'hA5A5A5A5, 4'hF);
      fork
         drive_aw(32'h0C);
         drive_w(32'hA5A5A5A5, 4'hF);
         drive_ar(32'h0C);
      join
      check("collision_rvalid", bus.rvalid, 1);
      wait_b();
      wait_r();
      do_read(32'h0C, 0);

      // mixed random traffic
      for (int i = 0; i < 8; i++) begin
         a = 32'($urandom_range(0, 63));
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         do_write(a, d, s, $urandom_range(0, 4) - 2);
         wait_b();
         do_read(32'($urandom_range(0, 63)), 0);
      end
      check_all_regs("random_regs");

      // reset while a write response is pending
      do_write(32'h10, 32'h11223344, 4'hF, 0);
      check("pre_rst_reg4", regs_out[4], 32'h11223344);
      #2;
      aresetn = 1'b0;
      #1;
      check("rst_mid_bvalid", bus.bvalid, 0);
      check("rst_mid_awready", bus.awready, 0);
      b_q.delete();
      for (int i = 0; i < NREGS; i++) model[i] = RST_VAL;
      check_all_regs("rst_mid_regs");
      tick();
      aresetn = 1'b1;
      tick();
      check("rerst_awready", bus.awready, 1);
      check("rerst_wready", bus.wready, 1);
      check("rerst_bvalid", bus.bvalid, 0);
      do_read(32'h10, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axil_regfile_slave.md
# axil_regfile_slave

AXI-Lite slave register file: the endpoint driven by the UART-bridged AXI-Lite master. Host writes and reads over UART become AXI-Lite transactions that land here. The block holds NUM_REGS 32-bit control registers and exposes them as a flat parallel output to the rest of the design. Write and read channels are independent, with byte-strobe support and decode-error reporting.

## Interface
Parameters:
- NUM_REGS, 16: number of 32-bit registers; power of two, 2..256.
- RESET_VALUE, 32'h0000_0000: reset value of every register.

Ports:
- aclk  in  1  clock; all logic is rising-edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axil  axil_if.s_axil  (pkg widths)  AXI-Lite slave carrying the following signals:
  - AW channel: awaddr, awvalid, awready.
  - W channel: wdata, wstrb, wvalid, wready.
  - B channel: bresp, bvalid, bready.
  - AR channel: araddr, arvalid, arready.
  - R channel: rdata, rresp, rvalid, rready.
  - prot signals are ignored.
- regs_out  out  NUM_REGS×32  current register contents; regs_out[i] is register i.

## Operation
- Decode: byte offset = addr; index = addr[2 +: $clog2(NUM_REGS)]; addr[1:0] ignored. The access is out of range when addr ≥ NUM_REGS*4.
- Write FSM states:
  - W_IDLE: awready=wready=1 until each is captured. AW and W may arrive in either order or in the same cycle. A captured channel drops its ready and holds the latched value.
  - W_IDLE → W_RESP: on the edge where the later of the two handshakes completes. At that same edge, an in-range write is applied per byte (byte k is written iff wstrb[k]). An out-of-range write is discarded.
  - W_RESP: bvalid=1, and bresp stays stable until bready. On the bvalid&bready edge, return to W_IDLE; awready and wready go to 1 in the next cycle.
- Read FSM states:
  - R_IDLE: arready=1.
  - R_IDLE → R_DATA: on the AR handshake edge, rdata and rresp are registered. rdata comes from the register state before that edge. Out-of-range reads give rdata=0.
  - R_DATA: rvalid=1, and rdata and rresp stay stable until rready. On the handshake edge, return to R_IDLE.
- Simultaneous read and write to the same register: a read whose AR handshake shares an edge with the write's final handshake returns the old value.
- bresp/rresp: OKAY 2'b00, or SLVERR 2'b10 (see Configuration).

## Timing
- During reset, all of the following are 0: awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata. regs_out = RESET_VALUE.
- Readies are registered. They become 1 in the first cycle after aresetn deasserts.
- Write latency: the updated regs_out value and bvalid=1 both appear in the cycle after the final AW/W handshake edge.
- Read latency: rvalid=1 in the cycle after the AR handshake.
- Throughput: at most one write per 2 cycles and one read per 2 cycles when bready/rready are held at 1.
- Reset mid-transaction:
  - Latched AW/W and pending responses are discarded.
  - bvalid and rvalid drop asynchronously.
  - Registers return to RESET_VALUE.

## Configuration
- Macro AXIL_REGFILE_SLVERR_EN, when defined: out-of-range accesses return SLVERR. Writes are still discarded and reads still return 0.
- When undefined: every response is OKAY. Out-of-range writes are silently dropped and reads return 0.

## Structure
- axil_pkg holds the following:
  - Constants AXIL_ADDR_WIDTH and AXIL_DATA_WIDTH (32).
  - AXIL_RESP_OKAY and AXIL_RESP_SLVERR.
  - typedef enum wr_state_t {W_IDLE, W_RESP}.
  - typedef enum rd_state_t {R_IDLE, R_DATA}.
- No sub-module. The block is one module with two independent FSMs and a strobe-masked register array.

## Test plan
- AW and W in the same cycle: awaddr=0x04, wdata=0xDEADBEEF, wstrb=4'hF → regs_out[1]=0xDEADBEEF and bvalid=1 one cycle later, with bresp=OKAY.
- W two cycles before AW: wdata=0x12345678 to addr 0x08 with wstrb=4'b0101, register previously 0xFFFFFFFF → register becomes 0xFF34FF78; wready stays 0 until B completes.
- Read-back: AR addr 0x04 after the first test → rvalid one cycle later with rdata=0xDEADBEEF; rdata stays stable while rready is held at 0 for 5 cycles.
- Out of range, NUM_REGS=16:
  - Write to 0x40 leaves all registers unchanged.
  - Read of 0x40 returns rdata=0.
  - Responses are SLVERR when AXIL_REGFILE_SLVERR_EN is defined, OKAY otherwise.
- Same-edge collision: AR to 0x0C on the same edge as a write of 0xA5A5A5A5 to 0x0C, old value 0 → read returns 0; a subsequent read returns 0xA5A5A5A5.
- Reset while bvalid is pending, bready=0 → bvalid=0 immediately and regs_out equals RESET_VALUE; awready=1 in the first cycle after release.
